// File: rtl/sec_counter_mod60_pkg.sv
// Shared constants and FSM state type for the seconds counter.
// Width and modulus must match the downstream 6-bit binary-to-BCD converter.
package sec_cnt_pkg;

    localparam int MOD60 = 60;
    localparam int CNT_W = 6;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

endpackage

// File: rtl/sec_counter_mod60_tick_prescaler.sv
// Free-running divider that flags the last cycle of each PRESCALE-long interval.
// It holds its value while disabled, so a paused partial interval resumes.
module tick_prescaler #(
    parameter int PRESCALE = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic En,
    input  logic Clr,
    output logic tick_pre
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LP_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign tick_pre = En && (r_cnt == LP_LAST);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (Clr) begin
            r_cnt <= '0;
        end else if (En) begin
            r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sec_counter_mod60.sv
// Seconds counter: run/stop FSM, prescaled up/down count modulo MODULUS,
// switch load with range check, and carry pulse for a cascaded minutes stage.
module sec_counter_mod60
    import sec_cnt_pkg::*;
#(
    parameter int PRESCALE = 50000000,
    parameter int MODULUS  = MOD60,
    parameter int WIDTH    = CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Count,
    output logic             Tick,
    output logic             Carry,
    output logic             LoadErr,
    output logic             Running
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    state_t           r_state;
    logic             w_tick_pre;
    logic             w_load_ok;
    logic             w_step;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock    (Clock),
        .Reset    (Reset),
        .En       (r_state == RUNNING),
        .Clr      (w_load_ok),
        .tick_pre (w_tick_pre)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_load_ok = Load && (LoadVal <= LP_MAX);
        w_step    = w_tick_pre && !w_load_ok;
        w_wrap    = Up ? (Count == LP_MAX) : (Count == '0);
        w_next    = Count;
        if (w_wrap) begin
            w_next = Up ? '0 : LP_MAX;
        end else begin
            w_next = Up ? Count + 1'b1 : Count - 1'b1;
        end
    end

    // Stop wins over Start in either state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= STOPPED;
            Running <= 1'b0;
        end else begin
            case (r_state)
                STOPPED: begin
                    if (Start && !Stop) begin
                        r_state <= RUNNING;
                        Running <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (Stop) begin
                        r_state <= STOPPED;
                        Running <= 1'b0;
                    end
                end
                default: begin
                    r_state <= STOPPED;
                    Running <= 1'b0;
                end
            endcase
        end
    end

    // An accepted load overrides and swallows any tick due on the same edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count   <= '0;
            Tick    <= 1'b0;
            Carry   <= 1'b0;
            LoadErr <= 1'b0;
        end else begin
            Tick    <= w_step;
            Carry   <= w_step && w_wrap;
            LoadErr <= Load && !w_load_ok;
            if (w_load_ok) begin
                Count <= LoadVal;
            end else if (w_step) begin
                Count <= w_next;
            end
        end
    end

endmodule
